// File: rtl/cache_port_arbiter_if.sv
// cache_port_arbiter_if: requester (req/write/addr/wr_data -> gnt/done/err/rd_data) and cache (address/write/start/data/oe/mem_done) bundle
interface cache_port_arbiter_if;
  logic [1:0] req, write, gnt, done, err;
  logic [1:0][7:0] addr;
  logic [1:0][31:0] wr_data;
  logic [31:0] rd_data, cache_data_out, cache_data_in;
  logic [7:0] cache_address;
  logic cache_write, cache_start, cache_data_oe, cache_mem_done;
  modport slave (
    input req, write, addr, wr_data, cache_data_in, cache_mem_done,
    output gnt, done, err, rd_data, cache_address, cache_write, cache_start, cache_data_out, cache_data_oe
  );
  modport master (
    output req, write, addr, wr_data, cache_data_in, cache_mem_done,
    input gnt, done, err, rd_data, cache_address, cache_write, cache_start, cache_data_out, cache_data_oe
  );
endinterface

// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter: round-robin share of one cache port by two requesters; ports clk, reset_n (sync active-low), bus (requester + cache handshake)
module cache_port_arbiter #(
  parameter int DEPTH = 16,
  parameter int TIMEOUT = 15
) (
  input logic clk,
  input logic reset_n,
  cache_port_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, DONE} state_t;
  state_t state;
  logic last, own, sel, timed_out;
  logic [7:0] cnt;
  always_comb begin
    sel = (bus.req == 2'b11) ? ~last : bus.req[1];
    timed_out = cnt == 8'(TIMEOUT - 1);
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      last <= 1'b1;
      own <= 1'b0;
      cnt <= '0;
      bus.gnt <= '0;
      bus.done <= '0;
      bus.err <= '0;
      bus.rd_data <= '0;
      bus.cache_address <= '0;
      bus.cache_write <= 1'b0;
      bus.cache_start <= 1'b0;
      bus.cache_data_out <= '0;
      bus.cache_data_oe <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|bus.req) begin
          own <= sel;
          bus.gnt <= 2'b01 << sel;
          if (bus.addr[sel] < 8'(DEPTH)) begin
            state <= ISSUE;
            bus.cache_start <= 1'b1;
            bus.cache_address <= bus.addr[sel];
            bus.cache_write <= bus.write[sel];
            bus.cache_data_out <= bus.wr_data[sel];
            bus.cache_data_oe <= bus.write[sel];
          end else begin
            state <= DONE;
            bus.done <= 2'b01 << sel;
            bus.err <= 2'b01 << sel;
          end
        end
        ISSUE: begin
          state <= WAIT_LOW;
          bus.gnt <= '0;
          bus.cache_start <= 1'b0;
          cnt <= '0;
        end
        WAIT_LOW, WAIT_HIGH: begin
          cnt <= cnt + 8'd1;
          if (state == WAIT_HIGH && bus.cache_mem_done) begin
            state <= DONE;
            bus.done <= 2'b01 << own;
            bus.cache_data_oe <= 1'b0;
            if (!bus.cache_write) bus.rd_data <= bus.cache_data_in;
          end else if (timed_out) begin
            state <= DONE;
            bus.done <= 2'b01 << own;
            bus.err <= 2'b01 << own;
            bus.cache_data_oe <= 1'b0;
          end else if (state == WAIT_LOW && !bus.cache_mem_done) begin
            state <= WAIT_HIGH;
          end
        end
        DONE: begin
          state <= IDLE;
          last <= own;
          bus.gnt <= '0;
          bus.done <= '0;
          bus.err <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_port_arbiter.sv
// tb_cache_port_arbiter: randomized and directed check of cache_port_arbiter against a transaction-timeline model
module tb_cache_port_arbiter;
  localparam int DEPTH = 16, TIMEOUT = 15;
  logic clk = 0, reset_n = 0;
  int vectors = 0, miscompares = 0, cyc = 0, t = 1000, cd = 0, cl = 0, force_d = -1, force_l = -1, done_at = 0, g, d;
  logic [31:0] cmem [16];
  logic [31:0] rmem [16];
  logic [1:0] egnt = 0, edone = 0, eerr = 0;
  logic estart = 0, eoe = 0, ewrite = 0, last = 1, busy = 0, ok = 0, w = 0, lwr = 0;
  logic [7:0] eaddr = 0, la = 0;
  logic [31:0] edata = 0, erd = 0;
  logic [80:0] act_v, exp_v;
  cache_port_arbiter_if bus();
  cache_port_arbiter #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  assign bus.cache_data_in = cmem[bus.cache_address[3:0]];
  assign act_v = {bus.gnt, bus.done, bus.err, bus.cache_start, bus.cache_data_oe, bus.cache_write, bus.cache_address, bus.cache_data_out, bus.rd_data};
  assign exp_v = {egnt, edone, eerr, estart, eoe, ewrite, eaddr, edata, erd};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic wait_ev(input bit on_done, input logic [1:0] m, output int c);
    c = -1;
    for (int i = 0; i < 60 && c < 0; i++) begin
      @(negedge clk);
      if (((on_done ? bus.done : bus.gnt) & m) != 0) c = cyc;
    end
    if (c < 0) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_%s: no pulse on mask %b within 60 cycles", on_done ? "done" : "gnt", m);
    end
  endtask

  task automatic req_on(input int n, input logic wr, input logic [7:0] a, input logic [31:0] dat);
    bus.req[n] = 1'b1;
    bus.write[n] = wr;
    bus.addr[n] = a;
    bus.wr_data[n] = dat;
  endtask

  initial begin
    bus.req = 0;
    bus.write = 0;
    bus.addr = 0;
    bus.wr_data = 0;
    for (int i = 0; i < 16; i++) begin
      cmem[i] = i * 32'h01010101;
      rmem[i] = i * 32'h01010101;
    end
    fork
      forever begin
        @(posedge clk);
        if (bus.cache_start) begin
          t = 0;
          if (bus.cache_write && bus.cache_data_oe) cmem[bus.cache_address[3:0]] = bus.cache_data_out;
        end else t++;
        #1 bus.cache_mem_done = !(t >= cd && t < cd + cl);
      end
      forever begin
        @(posedge clk);
        cyc++;
        egnt = 0;
        edone = 0;
        eerr = 0;
        estart = 0;
        if (!reset_n) begin
          busy = 0;
          last = 1;
          eoe = 0;
          ewrite = 0;
          eaddr = 0;
          edata = 0;
          erd = 0;
        end else if (busy) begin
          if (cyc == done_at) begin
            edone[w] = 1;
            eerr[w] = !ok;
            eoe = 0;
            if (ok && !lwr) erd = rmem[la[3:0]];
          end
          if (cyc == done_at + 1) begin
            last = w;
            busy = 0;
          end
        end else if (bus.req != 0) begin
          w = (bus.req == 2'b11) ? !last : bus.req[1];
          la = bus.addr[w];
          lwr = bus.write[w];
          egnt[w] = 1;
          busy = 1;
          if (la >= DEPTH) begin
            edone[w] = 1;
            eerr[w] = 1;
            done_at = cyc;
          end else begin
            estart = 1;
            eaddr = la;
            ewrite = lwr;
            edata = bus.wr_data[w];
            eoe = lwr;
            if (force_d >= 0) begin
              cd = force_d;
              cl = force_l;
            end else begin
              case ($urandom % 8)
                0: begin cd = 0; cl = 0; end
                1: begin cd = $urandom_range(0, 3); cl = 40; end
                default: begin cd = $urandom_range(0, 6); cl = $urandom_range(1, 9); end
              endcase
            end
            ok = cl > 0 && cd + cl + 1 <= TIMEOUT;
            done_at = cyc + 1 + (ok ? cd + cl + 1 : TIMEOUT);
            if (lwr) rmem[la[3:0]] = edata;
          end
        end
      end
      forever begin
        @(negedge clk);
        vectors++;
        if (act_v !== exp_v) begin
          miscompares++;
          $display("FAIL outputs cycle %0d: got %h required %h (gnt,done,err,start,oe,write,addr,dout,rd)", cyc, act_v, exp_v);
        end
      end
    join_none
    repeat (3) @(negedge clk);
    reset_n = 1;
    chk("reset_rd", bus.rd_data, 0);
    force_d = 0;
    force_l = 1;
    req_on(0, 1, 5, 32'hDEADBEEF);
    wait_ev(0, 2'b01, g);
    bus.req = 0;
    chk("t1_start", 32'(bus.cache_start), 1);
    chk("t1_oe", 32'(bus.cache_data_oe), 1);
    chk("t1_dout", bus.cache_data_out, 32'hDEADBEEF);
    wait_ev(1, 2'b01, d);
    chk("t1_latency", 32'(d - g), 3);
    chk("t1_err", 32'(bus.err), 0);
    req_on(1, 0, 5, 0);
    wait_ev(0, 2'b10, g);
    bus.req = 0;
    chk("t2_oe", 32'(bus.cache_data_oe), 0);
    wait_ev(1, 2'b10, d);
    chk("t2_rd", bus.rd_data, 32'hDEADBEEF);
    repeat (5) @(negedge clk);
    chk("t2_rd_held", bus.rd_data, 32'hDEADBEEF);
    req_on(0, 1, 1, 32'h11111111);
    req_on(1, 1, 2, 32'h22222222);
    for (int k = 0; k < 4; k++) begin
      wait_ev(0, 2'b11, g);
      chk($sformatf("t3_grant%0d", k), 32'(bus.gnt), (k % 2) ? 2 : 1);
    end
    bus.req = 0;
    repeat (20) @(negedge clk);
    req_on(0, 0, 16, 0);
    wait_ev(0, 2'b01, g);
    bus.req = 0;
    chk("t4_done_err", 32'({bus.done, bus.err}), 32'b0101);
    chk("t4_start", 32'(bus.cache_start), 0);
    repeat (3) @(negedge clk);
    chk("t4_rd", bus.rd_data, 32'hDEADBEEF);
    force_l = 0;
    req_on(0, 0, 3, 0);
    wait_ev(0, 2'b01, g);
    bus.req = 0;
    wait_ev(1, 2'b01, d);
    chk("t5_timeout_latency", 32'(d - g), 16);
    chk("t5_err", 32'(bus.err), 1);
    chk("t5_rd", bus.rd_data, 32'hDEADBEEF);
    force_l = 1;
    req_on(1, 0, 7, 0);
    wait_ev(1, 2'b10, d);
    bus.req = 0;
    chk("t5_next_err", 32'(bus.err), 0);
    chk("t5_next_rd", bus.rd_data, 32'h07070707);
    repeat (2) @(negedge clk);
    force_l = 3;
    req_on(0, 1, 9, 32'hCAFEF00D);
    wait_ev(0, 2'b01, g);
    bus.req = 0;
    repeat (2) @(negedge clk);
    reset_n = 0;
    @(negedge clk);
    chk("t6_reset_outs", 32'({bus.done, bus.cache_start, bus.cache_data_oe}), 0);
    chk("t6_reset_rd", bus.rd_data, 0);
    reset_n = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t6_no_done", 32'(bus.done), 0);
    end
    force_l = 1;
    req_on(0, 0, 9, 0);
    wait_ev(0, 2'b01, g);
    bus.req = 0;
    wait_ev(1, 2'b01, d);
    chk("t6_after_err", 32'(bus.err), 0);
    chk("t6_after_rd", bus.rd_data, 32'hCAFEF00D);
    force_d = -1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      reset_n = ($urandom % 400) != 0;
      for (int n = 0; n < 2; n++) begin
        if (bus.req[n] ? bus.gnt[n] : 1'b1) begin
          bus.req[n] = bus.req[n] ? $urandom % 2 == 0 : $urandom % 3 == 0;
          bus.write[n] = $urandom % 2 == 0;
          bus.addr[n] = 8'($urandom_range(0, 19));
          bus.wr_data[n] = $urandom;
        end
      end
    end
    bus.req = 0;
    reset_n = 1;
    repeat (40) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cache_port_arbiter.md
Name: cache_port_arbiter

Overview:
- Shares one port of the 16x32 dual-port cache SRAM between two requesters: requester 0 is instruction fetch and requester 1 is load/store.
- Round-robin arbitration. Drives the cache Start/Write/Address/Data handshake and waits for the cache MemDone low-then-high completion sequence.
- Returns read data, a done pulse and an error flag to the granted requester. Also guards against out-of-range addresses and a hung cache.
- One instance sits between the CPU front-end and each cache port.

Parameters:
- DEPTH, 16, number of valid cache words; addresses >= DEPTH are rejected.
- TIMEOUT, 15, maximum cycles spent waiting on MemDone before aborting with error.

Ports:
- Clk  in  1  system clock; all state changes on rising edge.
- Reset_n  in  1  synchronous active-low reset.
- Req_n (n=0,1)  in  1  request; held high until Gnt_n.
- Write_n (n=0,1)  in  1  1=write, 0=read; sampled at acceptance.
- Addr_n (n=0,1)  in  8  word address; sampled at acceptance.
- WrData_n (n=0,1)  in  32  write data; sampled at acceptance.
- Gnt_n (n=0,1)  out  1  one-cycle pulse: request accepted, inputs latched.
- Done_n (n=0,1)  out  1  one-cycle pulse: transaction finished.
- Err_n (n=0,1)  out  1  valid with Done_n; 1 = out-of-range address or timeout.
- RdData  out  32  read result; updated only on successful read completion, then held.
- Cache_Address  out  8  to cache Address.
- Cache_Write  out  1  to cache Write.
- Cache_Start  out  1  to cache Start; the cache acts on its rising edge.
- Cache_DataOut  out  32  write data toward cache tristate bus.
- Cache_DataOE  out  1  enables Cache_DataOut onto the cache DataIO bus.
- Cache_DataIn  in  32  cache DataIO bus as seen by the arbiter.
- Cache_MemDone  in  1  cache MemDone; idles high, falls after Start, rises when complete.

Behaviour:
- Reset (Reset_n=0 at a rising edge): state IDLE; all outputs 0, including RdData; round-robin pointer Last=1, so requester 0 wins the first tie; timeout counter 0.
- Reset mid-transaction: the transaction is abandoned. No Done/Err is issued, and Cache_Start/Cache_DataOE drop on the next edge.
- States: IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, DONE. All outputs are registered.
- IDLE:
  - Single Req_n: that requester wins.
  - Both Req high: the requester != Last wins.
  - Winner's Write/Addr/WrData are latched.
  - If latched Addr < DEPTH: go to ISSUE.
  - Otherwise go to DONE with Err set, and the cache is never started.
- ISSUE (1 cycle):
  - Gnt_n=1 and Cache_Start=1.
  - Cache_Address and Cache_Write are driven from latched values and held stable until DONE ends.
  - Cache_DataOE = latched Write, held through WAIT_HIGH.
  - Cache_DataOut = latched WrData.
  - Next state WAIT_LOW; timeout counter cleared.
- WAIT_LOW: Cache_Start=0. Move to WAIT_HIGH on the first cycle Cache_MemDone==0.
- WAIT_HIGH:
  - On the first cycle Cache_MemDone==1, go to DONE.
  - If the transaction is a read, capture Cache_DataIn into RdData on that same edge.
- Timeout:
  - The counter increments every cycle in WAIT_LOW/WAIT_HIGH.
  - When it reaches TIMEOUT-1 without completion, go to DONE with Err=1 and leave RdData unchanged.
  - Completion and timeout on the same cycle: completion wins.
- DONE (1 cycle):
  - Done_n=1 and Err_n as determined; Cache_DataOE=0.
  - Last = the granted requester.
  - Next state IDLE.
  - Out-of-range case: Gnt_n, Done_n and Err_n are all high in this same cycle.
- Latency: with MemDone low for exactly one cycle, Gnt_n comes 1 cycle after Req is sampled and Done_n comes 3 cycles after Gnt_n.
- Back-to-back: at least one IDLE cycle between transactions.
- The loser's Req stays pending; it is guaranteed service next, since it is then the only requester or wins the tie.
- The requester may change Addr/Write/WrData after Gnt_n.
- Req dropped after Gnt_n: no effect on the transaction in flight.
- Req still high after Done_n: treated as a new request.
- Only the granted requester's Gnt/Done/Err toggle; the other's stay 0.

Test Plan:
1. Reset, then Req_0 write Addr=5 WrData=32'hDEADBEEF; cache model drops MemDone 1 cycle after Start for 1 cycle → Gnt_0, Cache_Start 1 cycle, Cache_DataOE=1 with 32'hDEADBEEF, Done_0 3 cycles after Gnt_0, Err_0=0.
2. Req_1 read Addr=5 → RdData=32'hDEADBEEF at Done_1, Cache_DataOE stays 0, RdData held through later idle cycles.
3. Req_0 and Req_1 both high every cycle for 4 transactions → grants alternate 0,1,0,1; no grant is overlapped by another.
4. Req_0 read Addr=16 (DEPTH=16) → Gnt_0, Done_0 and Err_0 high in the same cycle; Cache_Start never asserts; RdData unchanged.
5. Cache model holds MemDone high forever after Start → Done_0 with Err_0=1 exactly TIMEOUT cycles after entering WAIT_LOW; the arbiter returns to IDLE and serves the next Req_1.
6. Reset_n=0 during WAIT_HIGH → next edge all outputs 0, no Done pulse; a new Req_0 after reset is granted normally.
